instr_sequencer: RTL and testbench

Multi-cycle sequencer for the custom CPU core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Owns the program counter and the instruction-register load strobe.
- Gates the decoder's RegWrite/MemWrite into one-cycle strobes and runs a req/ack handshake to data memory.
- Counts executed instructions and cycles, and stops on a halt opcode.

---
 rtl/instr_sequencer_if.sv | 9 +
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Data-memory request/acknowledge bundle between the sequencer and data memory.
interface instr_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the PC, gates decoder
// write enables into single-cycle strobes and runs the data-memory handshake.
module instr_sequencer #(
  parameter int                 mcodebits   = 4,
  parameter int                 pcwidth     = 10,
  parameter logic [mcodebits-1:0] HALT_OP   = 4'b1111,
  parameter int                 MEM_TIMEOUT = 15,
  parameter int                 cntwidth    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [mcodebits-1:0] opcode,
  input  logic                 dec_branch,
  input  logic                 dec_memwrite,
  input  logic                 dec_memtoreg,
  input  logic                 dec_regwrite,
  input  logic                 alu_taken,
  input  logic [pcwidth-1:0]   branch_target,
  instr_sequencer_if.master    mem,
  output logic [pcwidth-1:0]   pc,
  output logic                 ir_load,
  output logic                 rf_we,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [cntwidth-1:0]  instr_count,
  output logic [cntwidth-1:0]  cycle_count
);

  localparam int waitwidth = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t                state_reg, state_next;
  logic [pcwidth-1:0]    pc_reg;
  logic [pcwidth-1:0]    target_reg;
  logic                  taken_reg;
  logic [waitwidth-1:0]  wait_reg;
  logic                  error_reg;
  logic [cntwidth-1:0]   instr_count_reg;
  logic [cntwidth-1:0]   cycle_count_reg;
  logic                  mem_req_c, mem_we_c, timeout_c;

  // Strobes are decoded from the state register only, so an async reset
  // forces them low in the same cycle.
  always_comb begin
    state_next = state_reg;
    ir_load    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    rf_we      = 1'b0;
    timeout_c  = 1'b0;
    case (state_reg)
      IDLE, HALT: if (start) state_next = FETCH;
      FETCH: begin
        ir_load    = 1'b1;
        state_next = DECODE;
      end
      DECODE: state_next = (opcode == HALT_OP) ? HALT : EXEC;
      EXEC: state_next = (dec_memwrite | dec_memtoreg) ? MEM : WB;
      MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = dec_memwrite;
        if (mem.mem_ack) begin
          state_next = WB;
        end else if (wait_reg == waitwidth'(MEM_TIMEOUT - 1)) begin
          timeout_c  = 1'b1;
          state_next = HALT;
        end
      end
      WB: begin
        rf_we      = dec_regwrite & ~dec_memwrite;
        state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      target_reg      <= '0;
      taken_reg       <= 1'b0;
      wait_reg        <= '0;
      error_reg       <= 1'b0;
      instr_count_reg <= '0;
      cycle_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= (state_reg == MEM && !mem.mem_ack) ? wait_reg + 1'b1 : '0;
      if (timeout_c) error_reg <= 1'b1;
      // The cycle that drops into HALT is not counted, so a run of N busy
      // cycles reports N-1 elapsed cycles.
      if (busy && state_next != HALT && cycle_count_reg != '1)
        cycle_count_reg <= cycle_count_reg + 1'b1;
      case (state_reg)
        IDLE, HALT: begin
          if (start) begin
            pc_reg          <= '0;
            instr_count_reg <= '0;
            cycle_count_reg <= '0;
            error_reg       <= 1'b0;
          end
        end
        DECODE: begin
          if (opcode == HALT_OP && instr_count_reg != '1)
            instr_count_reg <= instr_count_reg + 1'b1;
        end
        EXEC: begin
          taken_reg  <= dec_branch & alu_taken;
          target_reg <= branch_target;
        end
        WB: begin
          pc_reg <= taken_reg ? target_reg : pc_reg + 1'b1;
          if (instr_count_reg != '1) instr_count_reg <= instr_count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_we   = mem_we_c;
  assign pc           = pc_reg;
  assign busy         = (state_reg != IDLE) && (state_reg != HALT);
  assign done         = (state_reg == HALT);
  assign error        = error_reg;
  assign instr_count  = instr_count_reg;
  assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-instruction vector table plus
// hand-written sequences for halt, timeout, PC wrap and mid-MEM reset.
module tb_instr_sequencer;
  localparam logic [3:0] HALT = 4'b1111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic       br = 1'b0, mw = 1'b0, mtr = 1'b0, rw = 1'b0, tk = 1'b0;
  logic [9:0] tgt = '0;
  logic [9:0] pc;
  logic       ir_load, rf_we, busy, done, error;
  logic [15:0] instr_count, cycle_count;

  int checks = 0;
  int errors = 0;
  int ack_delay = 1000;
  int mem_cnt = 0;
  int excl_viol = 0;

  instr_sequencer_if mif ();

  instr_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(op),
    .dec_branch(br), .dec_memwrite(mw), .dec_memtoreg(mtr), .dec_regwrite(rw),
    .alu_taken(tk), .branch_target(tgt), .mem(mif.master), .pc(pc),
    .ir_load(ir_load), .rf_we(rf_we), .busy(busy), .done(done), .error(error),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Memory model: acknowledge on the ack_delay-th MEM cycle (0-based).
  initial begin
    mif.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.mem_req) begin
        mif.mem_ack = (mem_cnt == ack_delay);
        mem_cnt++;
      end else begin
        mif.mem_ack = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if ((int'(ir_load) + int'(mif.mem_req) + int'(rf_we)) > 1 || (mif.mem_we && !mif.mem_req))
        excl_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic br, mw, mtr, rw, tk;
    logic [9:0] tgt;
    int ackd;
    int lat, req, we, rf, pc;
  } vec_t;

  vec_t vecs[12];

  task automatic set_dec(input vec_t v);
    op = v.op; br = v.br; mw = v.mw; mtr = v.mtr; rw = v.rw; tk = v.tk;
    tgt = v.tgt; ack_delay = v.ackd;
  endtask

  // From a done state: pulse start, land in FETCH and confirm the clean restart.
  task automatic restart(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_irload"}, ir_load, 1);
    check({tag, "_pc0"}, pc, 0);
    check({tag, "_done0"}, done, 0);
    check({tag, "_err0"}, error, 0);
    check({tag, "_icnt0"}, instr_count, 0);
  endtask

  initial begin
    int lat, req, we, rfc, rf_at, guard;
    bit fin;
    logic [31:0] mask;

    //            op    br mw mtr rw tk tgt  ackd  lat req we rf pc
    vecs[0]  = '{4'h0, 0, 0, 0, 1, 0, 0,   0,    4, 0, 0, 1, 1};
    vecs[1]  = '{4'h2, 0, 0, 1, 1, 0, 0,   0,    5, 1, 0, 1, 2};
    vecs[2]  = '{4'h2, 0, 0, 1, 1, 0, 0,   3,    8, 4, 0, 1, 3};
    vecs[3]  = '{4'h3, 0, 1, 0, 1, 0, 0,   1,    6, 2, 1, 0, 4};
    vecs[4]  = '{4'h0, 0, 0, 0, 0, 0, 0,   0,    4, 0, 0, 0, 5};
    vecs[5]  = '{4'h4, 1, 0, 0, 0, 1, 2,   0,    4, 0, 0, 0, 2};
    vecs[6]  = '{4'h0, 0, 0, 0, 1, 0, 0,   0,    4, 0, 0, 1, 3};
    vecs[7]  = '{4'h0, 0, 0, 0, 1, 0, 0,   0,    4, 0, 0, 1, 4};
    vecs[8]  = '{4'h0, 0, 0, 0, 1, 0, 0,   0,    4, 0, 0, 1, 5};
    vecs[9]  = '{4'h4, 1, 0, 0, 0, 0, 2,   0,    4, 0, 0, 0, 6};
    vecs[10] = '{4'h4, 0, 0, 0, 0, 1, 100, 0,    4, 0, 0, 0, 7};
    vecs[11] = '{4'h3, 1, 1, 0, 0, 1, 500, 0,    5, 1, 1, 0, 500};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_icnt", instr_count, 0);
    check("rst_ccnt", cycle_count, 0);
    check("rst_strobes", {ir_load, mif.mem_req, rf_we}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_hold", busy, 0);

    // Three ALU adds then HALT
    op = 4'h0; rw = 1'b1; start = 1'b1;
    mask = '0; fin = 0;
    for (int c = 1; c <= 30 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (rf_we) mask[c] = 1'b1;
      if (c == 13) op = HALT;
      if (done) begin
        fin = 1;
        check("alu_done_cycle", c, 15);
      end
    end
    check("alu_halted", fin, 1);
    check("alu_rf_cycles", mask, 32'h1110);
    check("alu_pc", pc, 3);
    check("alu_icnt", instr_count, 4);
    check("alu_ccnt", cycle_count, 13);
    check("alu_done", done, 1);

    // Table of single instructions, each starting in its FETCH cycle
    restart("run1");
    for (int i = 0; i < 12; i++) begin
      set_dec(vecs[i]);
      lat = 1; req = 0; we = 0; rfc = 0; rf_at = 0; fin = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
        @(negedge clk);
        if (ir_load || done) fin = 1;
        else begin
          lat++;
          if (mif.mem_req) req++;
          if (mif.mem_req && mif.mem_we) we = 1;
          if (rf_we) begin rfc++; rf_at = lat; end
        end
      end
      check($sformatf("v%0d_finished", i), fin, 1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_memreq", i), req, vecs[i].req);
      check($sformatf("v%0d_memwe", i), we, vecs[i].we);
      check($sformatf("v%0d_rfwe", i), rfc, vecs[i].rf);
      check($sformatf("v%0d_rfat", i), rf_at, vecs[i].rf ? vecs[i].lat : 0);
      check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d_icnt", i), instr_count, i + 1);
    end

    // Memory timeout: ack never arrives
    op = 4'h2; br = 0; mw = 0; mtr = 1; rw = 1; tk = 0; ack_delay = 1000;
    lat = 1; req = 0; rfc = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (done || ir_load) fin = 1;
      else begin
        lat++;
        if (mif.mem_req) req++;
        if (rf_we) rfc++;
      end
    end
    check("to_done", done, 1);
    check("to_error", error, 1);
    check("to_latency", lat, 18);
    check("to_memreq", req, 15);
    check("to_rfwe", rfc, 0);
    check("to_pc", pc, 500);
    check("to_icnt", instr_count, 12);

    // Restart clears error; run to pc=1023 and wrap
    op = 4'h0; mtr = 0; rw = 1;
    restart("run2");
    guard = 0;
    while (!(ir_load && pc == 10'd1023) && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_reached", pc, 1023);
    repeat (4) @(negedge clk);
    check("wrap_fetch", ir_load, 1);
    check("wrap_pc", pc, 0);
    op = HALT;
    guard = 0;
    while (!done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_done", done, 1);
    check("wrap_icnt", instr_count, 1025);
    check("wrap_ccnt", cycle_count, 4097);

    // Asynchronous reset in the middle of a load
    op = 4'h0; rw = 1;
    restart("run3");
    repeat (4) @(negedge clk);
    op = 4'h2; mtr = 1; ack_delay = 1000;
    guard = 0;
    while (!mif.mem_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("mr_in_mem", mif.mem_req, 1);
    check("mr_pc1", pc, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mr_memreq", mif.mem_req, 0);
    check("mr_rfwe", rf_we, 0);
    check("mr_pc", pc, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_icnt", instr_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mr_idle", busy, 0);

    check("strobe_exclusive", excl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
